pipe_front_regs: RTL

PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/flopenrc.sv | 23 ++
 rtl/pipe_front_regs.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the front-end pipeline registers
package pipe_pkg;

  // Decode control bundle layout: {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol[2:0]}
  localparam int CTRL_W         = 8;
  localparam int CTRL_REGWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_MEMWRITE  = 5;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 3;
  localparam int CTRL_ALUCTRL_L = 0;
  localparam int CTRL_ALUCTRL_W = 3;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch/Decode stage register contents
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } ifid_t;

  // Decode/Execute stage register contents
  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       signimm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
  } idex_t;

endpackage

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - register with async reset, load enable and synchronous clear
module flopenrc #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear only acts when enabled, so a held (stalled) stage ignores a pending clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/pipe_front_regs.sv
// rtl/pipe_front_regs.sv - PC, IF/ID and ID/EX registers with hazard controls and event counters
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_F,
  input  logic              stall_D,
  input  logic              flush_E,
  input  logic              pcsrc_D,
  input  logic [31:0]       pcbranch_D,
  input  logic [31:0]       instr_F,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [31:0]       rd1_D,
  input  logic [31:0]       rd2_D,
  input  logic [31:0]       signimm_D,
  input  logic [4:0]        rs_D,
  input  logic [4:0]        rt_D,
  input  logic [4:0]        rd_D,
  output logic [31:0]       pc_F,
  output logic [31:0]       instr_D,
  output logic [31:0]       pcplus4_D,
  output logic              valid_D,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [31:0]       rd1_E,
  output logic [31:0]       rd2_E,
  output logic [31:0]       signimm_E,
  output logic [4:0]        rs_E,
  output logic [4:0]        rt_E,
  output logic [4:0]        rd_E,
  output logic              valid_E,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              protocol_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0] w_pcplus4_F;
  logic [31:0] w_pc_next;
  ifid_t       w_ifid_d;
  ifid_t       r_ifid;
  idex_t       w_idex_d;
  idex_t       r_idex;
  logic        w_squash;
  logic        w_proto_viol;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_squash_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             r_protocol_err;

  assign w_pcplus4_F  = pc_F + 32'd4;
  assign w_pc_next    = pcsrc_D ? pcbranch_D : w_pcplus4_F;
  assign w_squash     = !stall_D && pcsrc_D;
  assign w_proto_viol = (stall_F != stall_D) || (stall_D && !flush_E);

  assign w_ifid_d = '{valid: 1'b1, instr: instr_F, pcplus4: w_pcplus4_F};

  // A bubble already in Decode travels on as a bubble because valid_D rides along
  assign w_idex_d = '{valid: r_ifid.valid, ctrl: ctrl_D, rd1: rd1_D, rd2: rd2_D,
                      signimm: signimm_D, rs: rs_D, rt: rt_D, rd: rd_D};

  flopenrc #(.W(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset_n(reset_n), .en(!stall_F), .clr(1'b0),
    .d(w_pc_next), .q(pc_F)
  );

  // A squash clears to all-zero, which is the NOP encoding with valid_D=0
  flopenrc #(.W($bits(ifid_t))) u_ifid (
    .clk(clk), .reset_n(reset_n), .en(!stall_D), .clr(pcsrc_D),
    .d(w_ifid_d), .q(r_ifid)
  );

  flopenrc #(.W($bits(idex_t))) u_idex (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(flush_E),
    .d(w_idex_d), .q(r_idex)
  );

  // Saturating hazard-event counters and sticky control-consistency flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt    <= '0;
      r_squash_cnt   <= '0;
      r_bubble_cnt   <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (stall_D && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_squash && (r_squash_cnt != CNT_MAX)) r_squash_cnt <= r_squash_cnt + CNT_ONE;
      if (flush_E && (r_bubble_cnt != CNT_MAX)) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      if (w_proto_viol) r_protocol_err <= 1'b1;
    end
  end

  assign instr_D      = r_ifid.instr;
  assign pcplus4_D    = r_ifid.pcplus4;
  assign valid_D      = r_ifid.valid;
  assign ctrl_E       = r_idex.ctrl;
  assign rd1_E        = r_idex.rd1;
  assign rd2_E        = r_idex.rd2;
  assign signimm_E    = r_idex.signimm;
  assign rs_E         = r_idex.rs;
  assign rt_E         = r_idex.rt;
  assign rd_E         = r_idex.rd;
  assign valid_E      = r_idex.valid;
  assign stall_cnt    = r_stall_cnt;
  assign squash_cnt   = r_squash_cnt;
  assign bubble_cnt   = r_bubble_cnt;
  assign protocol_err = r_protocol_err;

endmodule
